// File: rtl/axi_err_pkg.sv
// axi_err_pkg: shared response codes, FSM state types and queue sizing for the AXI error slave
package axi_err_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  localparam int PTR_W = 1;
endpackage

// File: rtl/axi_id_fifo.sv
// axi_id_fifo: sync ID FIFO (W x DEPTH); push_i/pop_i are ignored when full/empty, head_o is the oldest entry
module axi_id_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign full_o = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o = mem_q[rp_q];
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wp_q] <= din_i;
      wp_q <= wp_q + PW'(do_push);
      rp_q <= rp_q + PW'(do_pop);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/axi_err_slave.sv
// axi_err_slave: AXI default slave answering every burst with ERR_RESP; AR/R, AW/W/B channels plus saturating rd/wr error counters
module axi_err_slave
  import axi_err_pkg::*;
#(
  parameter int    ID_W     = 8,
  parameter int    DATA_W   = 32,
  parameter int    LEN_W    = 4,
  parameter int    AW_DEPTH = 2 ** PTR_W,
  parameter resp_t ERR_RESP = DECERR,
  parameter int    CNT_W    = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   AWID,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [CNT_W-1:0]  rd_err_cnt,
  output logic [CNT_W-1:0]  wr_err_cnt
);
  rstate_t rs_q, rs_d;
  wstate_t ws_q, ws_d;
  logic [ID_W-1:0] rid_q, rid_d, head;
  logic [LEN_W-1:0] rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [CNT_W-1:0] rd_q, wr_q;
  logic full, empty, push, pop;
  axi_id_fifo #(.W(ID_W), .DEPTH(AW_DEPTH)) u_fifo (
    .ACLK(ACLK), .ARESETn(ARESETn), .push_i(push), .pop_i(pop), .din_i(AWID),
    .full_o(full), .empty_o(empty), .head_o(head)
  );
  assign ARREADY = rs_q == R_IDLE;
  assign RVALID = rs_q == R_DATA;
  assign RID = RVALID ? rid_q : '0;
  assign RRESP = RVALID ? ERR_RESP : OKAY;
  assign RLAST = RVALID && rcnt_q == rlen_q;
  assign RDATA = '0;
  assign AWREADY = !full;
  assign WREADY = ws_q == W_DATA;
  assign BVALID = ws_q == W_RESP;
  assign BID = BVALID ? head : '0;
  assign BRESP = BVALID ? ERR_RESP : OKAY;
  assign push = AWVALID && AWREADY;
  assign pop = BVALID && BREADY;
  assign rd_err_cnt = rd_q;
  assign wr_err_cnt = wr_q;
  always_comb begin
    rs_d = rs_q;
    rid_d = rid_q;
    rlen_d = rlen_q;
    rcnt_d = rcnt_q;
    if (rs_q == R_IDLE) begin
      if (ARVALID) begin
        rs_d = R_DATA;
        rid_d = ARID;
        rlen_d = ARLEN;
        rcnt_d = '0;
      end
    end else if (RREADY) begin
      rs_d = RLAST ? R_IDLE : R_DATA;
      rcnt_d = RLAST ? rcnt_q : rcnt_q + LEN_W'(1);
    end
  end
  always_comb begin
    ws_d = ws_q == W_IDLE ? (empty ? W_IDLE : W_DATA) :
           ws_q == W_DATA ? (WVALID && WLAST ? W_RESP : W_DATA) :
           (BREADY ? W_IDLE : W_RESP);
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rs_q <= R_IDLE;
      ws_q <= W_IDLE;
      rid_q <= '0;
      rlen_q <= '0;
      rcnt_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rs_q <= rs_d;
      ws_q <= ws_d;
      rid_q <= rid_d;
      rlen_q <= rlen_d;
      rcnt_q <= rcnt_d;
      rd_q <= rd_q + CNT_W'(ARVALID && ARREADY && rd_q != '1);
      wr_q <= wr_q + CNT_W'(push && wr_q != '1);
    end
  end
endmodule
